fx_kport_pad: RTL and testbench



---
 rtl/fx_kport_pad.sv | 162 ++++++++++++++++
 tb/tb_fx_kport_pad.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_kport_pad.sv
// fx_kport_pad: pad-side model of a PC-FX K-port device (standard joypad).
// Answers the host latch/clock sequence by shifting a 32-bit device word out
// on KP_DIN (active-low, LSB first) and, in write direction, captures the
// 32-bit word the host shifts in on KP_DOUT.
module fx_kport_pad #(
  parameter logic [3:0] DEV_ID      = 4'hF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        CONNECTED,
  input  logic [15:0] BTN,
  input  logic        KP_LATCH,
  input  logic        KP_CLK,
  input  logic        KP_RW,
  input  logic        KP_DOUT,
  output logic        KP_DIN,
  output logic [31:0] RX_DATA,
  output logic        RX_VALID,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] WORD_BITS = 6'd32;

  // Pad inputs packed as {dout, rw, clk, latch}; idle level of every wire is 1.
  logic [3:0] r_sync [SYNC_STAGES];
  logic [1:0] r_prev;          // previous synchronized {clk, latch}

  state_t      r_state;
  logic [31:0] r_sr;
  logic [31:0] r_rx_sr;
  logic [5:0]  r_cnt;
  logic        r_rw;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;

  logic [3:0]  w_sync;
  logic        w_latch, w_kclk, w_rw, w_dout;
  logic        w_latch_rise, w_latch_fall, w_clk_rise;
  logic [31:0] w_tx_word;

  state_t      w_state_nxt;
  logic [31:0] w_sr_nxt;
  logic [31:0] w_rx_sr_nxt;
  logic [5:0]  w_cnt_nxt;
  logic        w_rw_nxt;
  logic        w_rx_load;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_latch = w_sync[0];
  assign w_kclk  = w_sync[1];
  assign w_rw    = w_sync[2];
  assign w_dout  = w_sync[3];

  assign w_latch_rise =  w_latch & ~r_prev[0];
  assign w_latch_fall = ~w_latch &  r_prev[0];
  assign w_clk_rise   =  w_kclk  & ~r_prev[1];

  // A disconnected port presents an all-zero word.
  assign w_tx_word = CONNECTED ? {DEV_ID, 12'h000, BTN} : 32'h0000_0000;

  // Synchronizer chain and edge-detect history, advancing only on CE.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'hF;
      r_prev <= 2'b11;
    end else if (CE) begin
      r_sync[0] <= {KP_DOUT, KP_RW, KP_CLK, KP_LATCH};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync[1:0];
    end
  end

  // Next-state and datapath decode for the transfer state machine.
  // NOTE: every signal written here gets a hold/default value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_rx_sr_nxt = r_rx_sr;
    w_cnt_nxt   = r_cnt;
    w_rw_nxt    = r_rw;
    w_rx_load   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_latch) w_state_nxt = ST_LOAD;
      end

      ST_LOAD: begin
        // Keep the word fresh while latch is held; clock edges are ignored.
        w_sr_nxt  = w_tx_word;
        w_cnt_nxt = 6'd0;
        if (w_latch_rise) begin
          w_rw_nxt    = w_rw;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_latch_fall) begin
          // Host restarted the sequence: drop the word in flight.
          w_state_nxt = ST_LOAD;
        end else if (w_clk_rise) begin
          if (r_rw) w_sr_nxt    = {1'b0, r_sr[31:1]};
          else      w_rx_sr_nxt = {~w_dout, r_rx_sr[31:1]};
          w_cnt_nxt = (r_cnt == WORD_BITS) ? r_cnt : r_cnt + 6'd1;
          if (r_cnt == WORD_BITS - 6'd1) begin
            w_state_nxt = ST_DONE;
            w_rx_load   = ~r_rw;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, shift registers and received-word output registers.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_rx_sr    <= '0;
      r_cnt      <= '0;
      r_rw       <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (CE) begin
      r_state    <= w_state_nxt;
      r_sr       <= w_sr_nxt;
      r_rx_sr    <= w_rx_sr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_rx_valid <= w_rx_load;
      if (w_rx_load) r_rx_data <= w_rx_sr_nxt;
    end
  end

  // Pad output is active-low; CONNECTED masks it without waiting for a clock.
  assign KP_DIN   = ~(CONNECTED & (r_state == ST_SHIFT) & r_rw & r_sr[0]);
  assign BUSY     = (r_state == ST_SHIFT);
  assign RX_DATA  = r_rx_data;
  assign RX_VALID = r_rx_valid;

endmodule

// File: tb/tb_fx_kport_pad.sv
// Bench for fx_kport_pad: acts as the host side of the K-port, decoding the
// pad's word bit by bit against a queue of expected KP_DIN levels and
// matching received words against a queue of expected RX_DATA values.
module tb_fx_kport_pad;

  logic        CLK;
  logic        RESn;
  logic        CE;
  logic        CONNECTED;
  logic [15:0] BTN;
  logic        KP_LATCH;
  logic        KP_CLK;
  logic        KP_RW;
  logic        KP_DOUT;
  logic        KP_DIN;
  logic [31:0] RX_DATA;
  logic        RX_VALID;
  logic        BUSY;

  int n_vec = 0;
  int n_err = 0;

  logic        din_q  [$];   // expected KP_DIN per host sample
  logic [31:0] rx_exp [$];   // expected received words
  logic [31:0] rx_obs [$];   // words seen with RX_VALID (one entry per cycle)
  int          din_low_cnt = 0;

  localparam int PH = 6;     // host half-period in system clocks

  fx_kport_pad #(.DEV_ID(4'hF), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RESn     (RESn),
    .CE       (CE),
    .CONNECTED(CONNECTED),
    .BTN      (BTN),
    .KP_LATCH (KP_LATCH),
    .KP_CLK   (KP_CLK),
    .KP_RW    (KP_RW),
    .KP_DOUT  (KP_DOUT),
    .KP_DIN   (KP_DIN),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observe RX_VALID pulses and any low level on KP_DIN.
  always @(negedge CLK) begin
    if (RX_VALID === 1'b1) rx_obs.push_back(RX_DATA);
    if (KP_DIN === 1'b0) din_low_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic host_latch(input logic rw);
    KP_RW    = rw;
    KP_LATCH = 1'b0;
    wait_cyc(PH);
    KP_LATCH = 1'b1;
    wait_cyc(PH);
  endtask

  task automatic host_clk();
    KP_CLK = 1'b0;
    wait_cyc(PH);
    KP_CLK = 1'b1;
    wait_cyc(PH);
  endtask

  // Host read of nclk bits; BTN is switched to btn_mid after the first rise.
  task automatic read_bits(input int nclk, input logic [31:0] word,
                           input logic [15:0] btn_mid, input string tag);
    logic [31:0] got;
    logic        exp_din;
    logic        exp_busy;
    for (int i = 0; i < nclk; i++) din_q.push_back((i < 32) ? ~word[i] : 1'b1);
    got = '0;
    for (int i = 0; i < nclk; i++) begin
      exp_din = din_q.pop_front();
      n_vec++;
      if (KP_DIN !== exp_din) begin
        n_err++;
        $display("FAIL %s din bit %0d: got %b want %b", tag, i, KP_DIN, exp_din);
      end
      if (i < 32) got[i] = ~KP_DIN;
      host_clk();
      if (i == 0) BTN = btn_mid;
      exp_busy = (i < 31);
      n_vec++;
      if (BUSY !== exp_busy) begin
        n_err++;
        $display("FAIL %s busy after rise %0d: got %b want %b", tag, i + 1, BUSY, exp_busy);
      end
    end
    if (nclk >= 32) begin
      n_vec++;
      if (got !== word) begin
        n_err++;
        $display("FAIL %s word: got %h want %h", tag, got, word);
      end
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({KP_DIN, BUSY, RX_VALID} !== 3'b100) begin
      n_err++;
      $display("FAIL reset outs din/busy/valid: got %b want 100", {KP_DIN, BUSY, RX_VALID});
    end
    n_vec++;
    if (RX_DATA !== 32'h0) begin
      n_err++;
      $display("FAIL reset rx_data: got %h want 00000000", RX_DATA);
    end
  endtask

  task automatic test_read_basic();
    BTN = 16'h0081;
    host_latch(1'b1);
    n_vec++;
    if (BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL read busy after latch: got %b want 1", BUSY);
    end
    read_bits(32, 32'hF000_0081, 16'h0081, "read_0081");
  endtask

  task automatic test_disconnected();
    int low0;
    // Combinational mask mid-transfer.
    BTN = 16'hFFFF;
    host_latch(1'b1);
    n_vec++;
    if (KP_DIN !== 1'b0) begin
      n_err++;
      $display("FAIL mask pre: got %b want 0", KP_DIN);
    end
    #1 CONNECTED = 1'b0;
    #1;
    n_vec++;
    if (KP_DIN !== 1'b1) begin
      n_err++;
      $display("FAIL mask on: got %b want 1", KP_DIN);
    end
    // Full transfer while disconnected: word is all zero.
    low0 = din_low_cnt;
    host_latch(1'b1);
    read_bits(32, 32'h0000_0000, 16'hFFFF, "disc");
    n_vec++;
    if (din_low_cnt != low0) begin
      n_err++;
      $display("FAIL disc din low cycles: got %0d want 0", din_low_cnt - low0);
    end
    CONNECTED = 1'b1;
  endtask

  task automatic test_write();
    logic [31:0] word;
    logic [31:0] exp_w;
    int          low0;
    word = 32'hA5A5_1234;
    BTN  = 16'hFFFF;
    rx_exp.push_back(word);
    low0 = din_low_cnt;
    host_latch(1'b0);
    for (int i = 0; i < 32; i++) begin
      KP_DOUT = ~word[i];
      host_clk();
    end
    KP_DOUT = 1'b1;
    wait_cyc(PH);
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL write busy at end: got %b want 0", BUSY);
    end
    n_vec++;
    if (rx_obs.size() != 1) begin
      n_err++;
      $display("FAIL write rx_valid cycles: got %0d want 1", rx_obs.size());
    end
    exp_w = rx_exp.pop_front();
    if (rx_obs.size() > 0) begin
      n_vec++;
      if (rx_obs[0] !== exp_w) begin
        n_err++;
        $display("FAIL write rx at valid: got %h want %h", rx_obs[0], exp_w);
      end
    end
    rx_obs.delete();
    n_vec++;
    if (RX_DATA !== exp_w) begin
      n_err++;
      $display("FAIL write rx_data hold: got %h want %h", RX_DATA, exp_w);
    end
    n_vec++;
    if (din_low_cnt != low0) begin
      n_err++;
      $display("FAIL write din low cycles: got %0d want 0", din_low_cnt - low0);
    end
  endtask

  task automatic test_abort();
    BTN = 16'h0001;
    host_latch(1'b1);
    read_bits(10, 32'hF000_0001, 16'h0001, "abort_part");
    BTN = 16'h0002;
    host_latch(1'b1);
    read_bits(32, 32'hF000_0002, 16'h0002, "abort_full");
    n_vec++;
    if (rx_obs.size() != 0) begin
      n_err++;
      $display("FAIL abort rx_valid cycles: got %0d want 0", rx_obs.size());
    end
    rx_obs.delete();
  endtask

  // Clock pulses while latch is low must not advance the word.
  task automatic test_latch_wins();
    BTN      = 16'h1234;
    KP_RW    = 1'b1;
    KP_LATCH = 1'b0;
    wait_cyc(PH);
    repeat (3) host_clk();
    KP_LATCH = 1'b1;
    wait_cyc(PH);
    read_bits(32, 32'hF000_1234, 16'h1234, "latch_wins");
  endtask

  task automatic test_ce_freeze();
    BTN = 16'h0081;
    host_latch(1'b1);
    CE = 1'b0;
    repeat (2) host_clk();
    n_vec++;
    if ({BUSY, KP_DIN} !== 2'b10) begin
      n_err++;
      $display("FAIL ce freeze busy/din: got %b want 10", {BUSY, KP_DIN});
    end
    CE = 1'b1;
    wait_cyc(PH);
    read_bits(32, 32'hF000_0081, 16'h0081, "ce_freeze");
  endtask

  // 40 pulses; BTN change mid-flight must not leak into the word.
  task automatic test_overrun();
    BTN = 16'h0081;
    host_latch(1'b1);
    read_bits(40, 32'hF000_0081, 16'hFF00, "overrun");
  endtask

  task automatic test_reset_mid();
    BTN = 16'hFFFF;
    host_latch(1'b1);
    read_bits(3, 32'hF000_FFFF, 16'hFFFF, "rst_mid");
    n_vec++;
    if ({BUSY, KP_DIN} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid pre busy/din: got %b want 10", {BUSY, KP_DIN});
    end
    #2 RESn = 1'b0;
    #1;
    n_vec++;
    if ({KP_DIN, BUSY, RX_VALID} !== 3'b100) begin
      n_err++;
      $display("FAIL rst_mid outs din/busy/valid: got %b want 100", {KP_DIN, BUSY, RX_VALID});
    end
    n_vec++;
    if (RX_DATA !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid rx_data: got %h want 00000000", RX_DATA);
    end
    wait_cyc(3);
    RESn = 1'b1;
    wait_cyc(2 * PH);
    n_vec++;
    if ({KP_DIN, BUSY} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid after release din/busy: got %b want 10", {KP_DIN, BUSY});
    end
    n_vec++;
    if (rx_obs.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid rx_valid cycles: got %0d want 0", rx_obs.size());
    end
  endtask

  initial begin
    RESn      = 1'b0;
    CE        = 1'b1;
    CONNECTED = 1'b1;
    BTN       = 16'h0000;
    KP_LATCH  = 1'b1;
    KP_CLK    = 1'b1;
    KP_RW     = 1'b1;
    KP_DOUT   = 1'b1;
    wait_cyc(3);
    test_reset();
    RESn = 1'b1;
    wait_cyc(PH);

    test_read_basic();
    test_disconnected();
    test_write();
    test_abort();
    test_latch_wins();
    test_ce_freeze();
    test_overrun();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
